// File: rtl/test_sequencer_if.sv
// Signal bundle between the test sequencer, the vector ROM and the unit under test.
// master: the sequencer side; slave: the harness side (ROM, DUT and result observers).
interface test_sequencer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 8
);
    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic [IN_WIDTH+OUT_WIDTH-1:0] rom_data;
    logic [IN_WIDTH-1:0]           dut_in;
    logic                          dut_start;
    logic                          dut_done;
    logic [OUT_WIDTH-1:0]          dut_out;
    logic [ADDR_WIDTH-1:0]         test;
    logic                          result;
    logic                          finished;
    logic [ADDR_WIDTH:0]           pass_count;

    modport master (
        output rom_addr,
        input  rom_data,
        output dut_in,
        output dut_start,
        input  dut_done,
        input  dut_out,
        output test,
        output result,
        output finished,
        output pass_count
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  dut_in,
        input  dut_start,
        output dut_done,
        output dut_out,
        input  test,
        input  result,
        input  finished,
        input  pass_count
    );
endinterface

// File: rtl/test_sequencer.sv
// Walks a ROM of test vectors through a unit under test and reports a sticky
// pass/fail verdict, the current (or failing) test index and a pass counter.
//
// state | meaning
// IDLE  | just out of reset, moves to FETCH on the first cycle with reset high
// FETCH | rom_addr presents the current test index (ROM answers next cycle)
// LOAD  | stimulus and expected value latched from rom_data
// START | one-cycle dut_start pulse, timeout counter cleared
// WAIT  | waiting for dut_done, counting toward TIMEOUT
// CHECK | captured result compared with expected value
// PASS  | every vector matched; terminal until reset
// FAIL  | mismatch or timeout; test holds the failing index; terminal until reset
module test_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_TESTS  = 16,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    test_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT,
        CHECK,
        PASS,
        FAIL
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_TEST = ADDR_WIDTH'(NUM_TESTS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   test_q, test_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic [IN_WIDTH-1:0]     dut_in_q, dut_in_d;
    logic [OUT_WIDTH-1:0]    expected_q, expected_d;
    logic [OUT_WIDTH-1:0]    captured_q, captured_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]     pass_q, pass_d;
    logic                    start_q;
    logic                    result_q;
    logic                    finished_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            test_q     <= '0;
            rom_addr_q <= '0;
            dut_in_q   <= '0;
            expected_q <= '0;
            captured_q <= '0;
            cnt_q      <= '0;
            pass_q     <= '0;
            start_q    <= 1'b0;
            result_q   <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            test_q     <= test_d;
            rom_addr_q <= test_d;
            dut_in_q   <= dut_in_d;
            expected_q <= expected_d;
            captured_q <= captured_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            // Outputs are registered from the next state so they line up with it.
            start_q    <= (state_d == START);
            result_q   <= (state_d == PASS);
            finished_q <= (state_d == PASS) || (state_d == FAIL);
        end
    end

    always_comb begin
        state_d    = state_q;
        test_d     = test_q;
        dut_in_d   = dut_in_q;
        expected_d = expected_q;
        captured_d = captured_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                dut_in_d   = bus.rom_data[IN_WIDTH-1:0];
                expected_d = bus.rom_data[IN_WIDTH +: OUT_WIDTH];
                state_d    = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion on the last allowed cycle still counts as done.
                if (bus.dut_done) begin
                    captured_d = bus.dut_out;
                    state_d    = CHECK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (captured_q == expected_q) begin
                    pass_d = pass_q + 1'b1;
                    if (test_q == LAST_TEST) begin
                        state_d = PASS;
                    end else begin
                        test_d  = test_q + 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = FAIL;
                end
            end
            PASS, FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.dut_in     = dut_in_q;
    assign bus.dut_start  = start_q;
    assign bus.test       = test_q;
    assign bus.result     = result_q;
    assign bus.finished   = finished_q;
    assign bus.pass_count = pass_q;
endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: a ROM and a behavioural unit under test drive the
// sequencer; each run's expected verdict is queued and checked when finished rises.
module tb_test_sequencer;
    localparam int AW = 4;
    localparam int IW = 16;
    localparam int OW = 8;

    typedef struct {
        string name;
        int    test;
        int    result;
        int    pass;
        int    lat;
        int    starts;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    test_sequencer_if #(.ADDR_WIDTH(AW), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    test_sequencer #(
        .ADDR_WIDTH(AW),
        .NUM_TESTS (16),
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .TIMEOUT   (64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sb_done  = 0;
    exp_t exp_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Vector i: stimulus {hi,lo}; a correct unit returns hi ^ lo.
    logic [IW+OW-1:0] rom_mem [16];

    function automatic logic [IW+OW-1:0] make_vec(input int i);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(8'h11 * i + 8'h3C);
        lo = 8'(8'h2B * i + 8'h07);
        return {hi ^ lo, hi, lo};
    endfunction

    // Behavioural unit under test.
    int mdl_hang_vec   = -1;
    int mdl_slow_vec   = -1;
    int mdl_slow_delay = 1;
    bit mdl_stuck      = 1'b0;
    int left           = 0;

    always @(posedge clk) begin
        logic done_n;
        bus.rom_data <= rom_mem[bus.rom_addr];
        bus.dut_out  <= bus.dut_in[15:8] ^ bus.dut_in[7:0];
        if (bus.dut_start && mdl_hang_vec != int'(bus.test))
            left = (int'(bus.test) == mdl_slow_vec) ? mdl_slow_delay : 1;
        done_n = mdl_stuck;
        if (left > 0) begin
            left--;
            if (left == 0) done_n = 1'b1;
        end
        bus.dut_done <= done_n;
    end

    // Cycle / pulse bookkeeping; cyc-1 is the distance from the first FETCH.
    int  cyc = 0;
    int  starts = 0;
    int  wide = 0;
    int  glitch = 0;
    bit  prev_start = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            cyc = 0; starts = 0; wide = 0; glitch = 0; prev_start = 1'b0;
        end else begin
            cyc++;
            if (bus.dut_start) starts++;
            if (bus.dut_start && prev_start) wide++;
            if (bus.result && !bus.finished) glitch++;
            prev_start = bus.dut_start;
        end
    end

    // Monitor: pops the expected verdict when finished rises.
    initial begin
        bit   fin_q;
        exp_t e;
        int   lat_seen;
        int   starts_seen;
        fin_q = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.finished && !fin_q) begin
                lat_seen    = cyc - 1;
                starts_seen = starts;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_finish: got finished=1 required no pending run");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_test"},   bus.test,       e.test);
                    chk({e.name, "_result"}, bus.result,     e.result);
                    chk({e.name, "_pass"},   bus.pass_count, e.pass);
                    chk({e.name, "_lat"},    lat_seen,       e.lat);
                    chk({e.name, "_starts"}, starts_seen,    e.starts);
                    chk({e.name, "_wide"},   wide,           0);
                    chk({e.name, "_glitch"}, glitch,         0);
                    repeat (8) @(negedge clk);
                    chk({e.name, "_hold_starts"}, starts,       e.starts);
                    chk({e.name, "_hold_fin"},    bus.finished, 1);
                    chk({e.name, "_hold_test"},   bus.test,     e.test);
                    chk({e.name, "_hold_res"},    bus.result,   e.result);
                end
                sb_done++;
            end
            fin_q = bus.finished;
        end
    end

    function automatic longint out_bits();
        return longint'({bus.rom_addr, bus.test, bus.dut_in, bus.dut_start,
                         bus.result, bus.finished, bus.pass_count});
    endfunction

    task automatic push_exp(input string nm, input int t, input int r, input int p,
                            input int lat, input int st);
        exp_t e;
        e.name = nm; e.test = t; e.result = r; e.pass = p; e.lat = lat; e.starts = st;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string nm, input int target);
        for (int i = 0; i < 3000 && sb_done < target; i++) @(negedge clk);
        if (sb_done < target) begin
            n_checks++;
            $display("FAIL %s_timeout: got no finished within 3000 cycles, required finished=1", nm);
            exp_q.delete();
            sb_done = target;
        end
    endtask

    task automatic run_scn(input string nm, input int t, input int r, input int p,
                           input int lat, input int st);
        int target;
        target = sb_done + 1;
        push_exp(nm, t, r, p, lat, st);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_done(nm, target);
    endtask

    task automatic model_defaults();
        mdl_hang_vec = -1; mdl_slow_vec = -1; mdl_slow_delay = 1; mdl_stuck = 1'b0;
        for (int i = 0; i < 16; i++) rom_mem[i] = make_vec(i);
    endtask

    initial begin
        int  target;
        bit  found;
        model_defaults();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_vals", out_bits(), 0);

        run_scn("all_pass", 15, 1, 16, 80, 16);

        rom_mem[5] = {8'hA5, 16'h5A00};
        run_scn("mismatch_v5", 5, 0, 5, 30, 6);
        model_defaults();

        mdl_hang_vec = 0;
        run_scn("hang_v0", 0, 0, 0, 67, 1);
        model_defaults();

        mdl_slow_vec = 0; mdl_slow_delay = 64;
        run_scn("done_at_64", 15, 1, 16, 143, 16);

        mdl_slow_vec = 2; mdl_slow_delay = 65;
        run_scn("done_at_65_v2", 2, 0, 2, 77, 3);
        model_defaults();

        // Reset during WAIT of vector 3; the abandoned completion lands in FETCH.
        mdl_slow_vec = 3; mdl_slow_delay = 4;
        target = sb_done + 1;
        push_exp("reset_restart", 15, 1, 16, 83, 16);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.dut_start && bus.test == 4'd3) found = 1'b1;
        end
        chk("reach_v3_start", found, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrun_reset_vals", out_bits(), 0);
        wait_done("reset_restart", target);
        model_defaults();

        mdl_stuck = 1'b1;
        run_scn("done_stuck", 15, 1, 16, 80, 16);
        model_defaults();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
- Controller that drives a unit under test (DUT) through a ROM of test vectors.
- For each vector it fetches the vector, applies the stimulus, pulses start and waits for done, then compares the DUT output against the expected value.
- It publishes the current test index, a sticky pass/fail result and a finished flag.
- It sits between the test-vector ROM and the DUT inside the lab checker harness, and replaces ad-hoc sequencing in the checker.

Parameters:
- ADDR_WIDTH, 4, width of the test index and ROM address (matches `TEST_I_ADDR_WIDTH).
- NUM_TESTS, 16, number of vectors to run, 1..2^ADDR_WIDTH.
- IN_WIDTH, 16, DUT stimulus width.
- OUT_WIDTH, 8, DUT result width.
- TIMEOUT, 64, maximum cycles spent in WAIT before declaring failure, >=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- rom_addr  output  ADDR_WIDTH  ROM read address. ROM read latency is 1 cycle.
- rom_data  input  IN_WIDTH+OUT_WIDTH  vector: [IN_WIDTH-1:0] is the stimulus, upper OUT_WIDTH bits are the expected value.
- dut_in  output  IN_WIDTH  stimulus applied to the DUT. Held stable from LOAD until the next LOAD.
- dut_start  output  1  one-cycle start pulse to the DUT.
- dut_done  input  1  DUT completion strobe. dut_out is valid in the same cycle.
- dut_out  input  OUT_WIDTH  DUT result.
- test  output  ADDR_WIDTH  index of the current test. After failure, index of the failing test.
- result  output  1  1 only when all NUM_TESTS vectors passed.
- finished  output  1  1 once the run has ended, by pass or by fail.
- pass_count  output  ADDR_WIDTH+1  number of vectors passed so far.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State = IDLE.
  - rom_addr, test, dut_in, expected register, timeout counter and pass_count = 0.
  - dut_start, result and finished = 0.
  - Applies from any state, mid-test included. Any DUT operation in flight is abandoned, and a late dut_done arriving after reset is ignored.
- States: IDLE, FETCH, LOAD, START, WAIT, CHECK, PASS, FAIL. Registered outputs throughout.
- IDLE -> FETCH on the first cycle with reset==1.
- FETCH: rom_addr = test. Next state LOAD.
- LOAD: latch rom_data; dut_in <= stimulus field, expected <= upper field. Next state START.
- START: dut_start = 1 for exactly this cycle; timeout counter cleared. Next state WAIT.
- WAIT:
  - dut_done is sampled only in WAIT. A dut_done seen in FETCH, LOAD or START is ignored.
  - On dut_done==1: capture dut_out, go to CHECK.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no done, go to FAIL.
  - If done arrives on that same cycle, done wins and the state goes to CHECK.
- CHECK, captured value == expected:
  - pass_count increments.
  - If test == NUM_TESTS-1, go to PASS.
  - Otherwise test increments, then go to FETCH.
- CHECK, mismatch: go to FAIL; test is not incremented.
- PASS: result = 1, finished = 1. Terminal until reset.
- FAIL: result = 0, finished = 1, test holds the failing index. Terminal until reset.
- result stays 0 throughout the run; it never pulses.
- Per-vector cost: FETCH+LOAD+START+WAIT+CHECK = 5 cycles when done arrives on the first WAIT cycle. The first FETCH occurs 1 cycle after reset release.
- test wraps only through reset; it never exceeds NUM_TESTS-1.
- pass_count saturation is not needed, since its maximum is NUM_TESTS <= 2^ADDR_WIDTH.
- dut_done held high continuously produces one completion per WAIT visit.
- dut_out is don't-care outside done cycles.

Test Plan:
- Defaults, DUT model returning the expected value 1 cycle after start for all 16 vectors -> dut_start pulses 16 times, each 1 cycle wide. pass_count=16, test=15, result=1, finished=1, 80 cycles after the first FETCH.
- Vector 5 expected 0xA5, DUT returns 0x5A -> finished=1, result=0, test=5, pass_count=5. No further dut_start pulses.
- DUT never asserts done on vector 0 -> FAIL after 64 WAIT cycles; test=0, pass_count=0, finished=1, result=0.
- dut_done asserted on exactly the 64th WAIT cycle -> treated as done, check proceeds, no timeout.
- reset driven low for 1 cycle during WAIT of vector 3 -> the next cycle shows all outputs at reset values. The sequencer restarts from test=0, and a stale dut_done arriving in IDLE or FETCH is ignored.
- dut_done stuck high from the start cycle onward, matching data -> exactly one pass per vector. Completes with result=1 in 5 cycles per vector.
